// File: rtl/instr_seq_pkg.sv
// Shared types and encodings for the instr_sequencer control block.
// The retire counter is enabled by defining INSTR_SEQ_RETIRE_CNT_EN.
package instr_seq_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned RETIRED_W  = 32;
  localparam int unsigned PC_STEP    = 4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_CTRL_W-1:0] ALU_CMP = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_TRAP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ADDI    = 2'd0,
    CLS_BNE     = 2'd1,
    CLS_ILLEGAL = 2'd2
  } cls_t;

  // Map opcode/funct3 onto the supported instruction classes.
  function automatic cls_t classify(input logic [6:0] opcode, input logic [2:0] funct3);
    if (opcode == OPC_OP_IMM && funct3 == F3_ADDI) return CLS_ADDI;
    if (opcode == OPC_BRANCH && funct3 == F3_BNE)  return CLS_BNE;
    return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/instr_sequencer_imm_gen.sv
// I-type and B-type immediate extraction with sign extension.
module imm_gen
  import instr_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [INSTR_W-1:0]    ir,
  output logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] imm_b
);

  localparam int unsigned I_W = 12;
  localparam int unsigned B_W = 13;

  logic [I_W-1:0] i_raw;
  logic [B_W-1:0] b_raw;
  logic           unused_ir_bits;

  // Raw immediate fields; B-type offsets are always even.
  assign i_raw = ir[31:20];
  assign b_raw = {ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

  // Sign-extend to the datapath width.
  assign imm_i = DATA_WIDTH'($signed(i_raw));
  assign imm_b = DATA_WIDTH'($signed(b_raw));

  // Register-address and opcode bits are not part of either immediate.
  assign unused_ir_bits = ^{ir[19:12], ir[6:0]};

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the addi/bne subset.
// Optional retire counter: define INSTR_SEQ_RETIRE_CNT_EN to add the 'retired' port.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  imem_req,
  input  logic                  imem_valid,
  input  logic [INSTR_W-1:0]    instr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [ALU_CTRL_W-1:0] ALU_ctrl,
  output logic                  ALUsrc,
  output logic                  RegWrite,
  input  logic                  eq,
  output logic                  trap
`ifdef INSTR_SEQ_RETIRE_CNT_EN
  ,
  output logic [RETIRED_W-1:0]  retired
`endif
);

  state_t                state;
  cls_t                  cls;
  cls_t                  dec_cls;
  logic [INSTR_W-1:0]    ir;
  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [ADDR_WIDTH-1:0] pc_seq;
  logic [ADDR_WIDTH-1:0] pc_tgt;
  logic                  bne_taken;
  logic                  exec_trap;
  logic                  exec_retire;

  imm_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_gen (
    .ir    (ir),
    .imm_i (imm_i),
    .imm_b (imm_b)
  );

  // Decode classification of the held instruction.
  assign dec_cls = classify(ir[6:0], ir[14:12]);

  // Next-PC candidates; both wrap modulo 2^ADDR_WIDTH.
  assign pc_seq = pc + ADDR_WIDTH'(PC_STEP);
  assign pc_tgt = pc + ADDR_WIDTH'($signed(ImmOp));

  // Branch resolution using the ALU equality flag sampled at the end of EXEC.
  assign bne_taken   = (cls == CLS_BNE) && !eq;
  assign exec_trap   = bne_taken && (pc_tgt[1:0] != 2'b00);
  assign exec_retire = (state == ST_EXEC) && !exec_trap;

  // Register addresses are straight IR fields.
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign rd  = ir[11:7];

  // Moore decode of state and class; reset masks the request and write strobe.
  assign imem_req = (state == ST_FETCH) && run && !rst;
  assign RegWrite = (state == ST_EXEC) && (cls == CLS_ADDI) && !rst;
  assign ALUsrc   = (state == ST_EXEC) && (cls == CLS_ADDI);
  assign ALU_ctrl = ((state == ST_EXEC) && (cls == CLS_BNE)) ? ALU_CMP : ALU_ADD;

  // Sequencer FSM with PC, IR, immediate and sticky trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      cls   <= CLS_ILLEGAL;
      ir    <= '0;
      ImmOp <= '0;
      pc    <= RESET_PC;
      trap  <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (run && imem_valid) begin
            ir    <= instr;
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            CLS_ADDI: begin
              ImmOp <= imm_i;
              state <= ST_EXEC;
            end
            CLS_BNE: begin
              ImmOp <= imm_b;
              state <= ST_EXEC;
            end
            default: begin
              trap  <= 1'b1;
              state <= ST_TRAP;
            end
          endcase
        end
        ST_EXEC: begin
          if (exec_trap) begin
            trap  <= 1'b1;
            state <= ST_TRAP;
          end else begin
            pc    <= bne_taken ? pc_tgt : pc_seq;
            state <= ST_FETCH;
          end
        end
        ST_TRAP: begin
          trap <= 1'b1;
        end
        default: begin
          state <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  // Count instructions that complete back into FETCH; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= '0;
    end else if (exec_retire) begin
      retired <= retired + RETIRED_W'(1);
    end
  end
`else
  logic unused_retire;
  assign unused_retire = exec_retire;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer.
module tb_instr_sequencer;

  localparam logic [31:0] ADDI_X1 = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] BNE_M8  = 32'hFE20_9CE3; // bne x1,x2,-8
  localparam logic [31:0] BNE_P6  = 32'h0020_9363; // bne x1,x2,+6
  localparam logic [31:0] ILLEGAL = 32'h0000_0033; // add (unsupported)

  logic        clk = 1'b0;
  logic        rst, run, imem_valid, eq;
  logic [31:0] instr;
  logic        imem_req, ALUsrc, RegWrite, trap;
  logic [31:0] pc, ImmOp;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  ALU_ctrl;

  logic        w_rst, w_run, w_valid;
  logic [31:0] w_instr;
  logic        w_req, w_regwrite;
  logic [31:0] w_pc;
  logic [4:0]  w_unused_rs1, w_unused_rs2, w_unused_rd;
  logic [31:0] w_unused_imm;
  logic [2:0]  w_unused_alu;
  logic        w_unused_src, w_unused_trap;

`ifdef INSTR_SEQ_RETIRE_CNT_EN
  logic [31:0] retired;
  logic [31:0] w_unused_retired;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_sequencer u_dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .imem_req   (imem_req),
    .imem_valid (imem_valid),
    .instr      (instr),
    .pc         (pc),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
    .ImmOp      (ImmOp),
    .ALU_ctrl   (ALU_ctrl),
    .ALUsrc     (ALUsrc),
    .RegWrite   (RegWrite),
    .eq         (eq),
    .trap       (trap)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    .retired    (retired)
`endif
  );

  instr_sequencer #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk        (clk),
    .rst        (w_rst),
    .run        (w_run),
    .imem_req   (w_req),
    .imem_valid (w_valid),
    .instr      (w_instr),
    .pc         (w_pc),
    .rs1        (w_unused_rs1),
    .rs2        (w_unused_rs2),
    .rd         (w_unused_rd),
    .ImmOp      (w_unused_imm),
    .ALU_ctrl   (w_unused_alu),
    .ALUsrc     (w_unused_src),
    .RegWrite   (w_regwrite),
    .eq         (1'b0),
    .trap       (w_unused_trap)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,
    .retired    (w_unused_retired)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present w for one fetch cycle, then DECODE, returning inside the cycle after DECODE.
  task automatic to_exec(input logic [31:0] w, input logic e);
    @(negedge clk); run = 1'b1; imem_valid = 1'b1; instr = w; eq = e; #1;
    @(negedge clk); imem_valid = 1'b0; #1;
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; imem_valid = 1'b0; #1;
    @(negedge clk); rst = 1'b0; #1;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; imem_valid = 1'b0; instr = '0; eq = 1'b0;
    w_rst = 1'b1; w_run = 1'b0; w_valid = 1'b0; w_instr = '0;

    // Reset behaviour
    @(negedge clk); #1;
    chk("req_in_rst", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_ctrl", 32'({ALU_ctrl, ALUsrc, trap}), 32'd0);
    chk("rst_imm", ImmOp, 32'd0);
    chk("rst_regs", 32'({rs1, rs2, rd}), 32'd0);

    // addi with imem_valid delayed two cycles
    @(negedge clk); rst = 1'b0; #1;
    chk("req_after_rst", 32'(imem_req), 32'd1);
    @(negedge clk); #1;
    chk("stall_req", 32'(imem_req), 32'd1);
    @(negedge clk); imem_valid = 1'b1; instr = ADDI_X1; #1;
    @(negedge clk); imem_valid = 1'b0; #1;
    chk("decode_req", 32'(imem_req), 32'd0);
    chk("decode_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk); #1;
    chk("addi_regwrite", 32'(RegWrite), 32'd1);
    chk("addi_imm", ImmOp, 32'd5);
    chk("addi_src", 32'(ALUsrc), 32'd1);
    chk("addi_alu", 32'(ALU_ctrl), 32'd0);
    chk("addi_rd", 32'(rd), 32'd1);
    chk("addi_pc_hold", pc, 32'd0);
    @(negedge clk); #1;
    chk("addi_pc", pc, 32'd4);
    chk("addi_pulse_end", 32'(RegWrite), 32'd0);

    // Reach pc=8, then bne -8 taken
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    chk("pc_8", pc, 32'd8);
    to_exec(BNE_M8, 1'b0);
    chk("bne_alu", 32'(ALU_ctrl), 32'd7);
    chk("bne_src", 32'(ALUsrc), 32'd0);
    chk("bne_regwrite", 32'(RegWrite), 32'd0);
    chk("bne_imm", ImmOp, 32'hFFFF_FFF8);
    @(negedge clk); #1;
    chk("bne_taken_pc", pc, 32'd0);

    // Back to pc=8, then bne -8 not taken
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    to_exec(BNE_M8, 1'b1);
    chk("bne_nt_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk); #1;
    chk("bne_nt_pc", pc, 32'd12);

    // Misaligned taken branch: 12 + 6
    to_exec(BNE_P6, 1'b0);
    chk("bne6_imm", ImmOp, 32'd6);
    @(negedge clk); imem_valid = 1'b1; #1;
    chk("mis_trap", 32'(trap), 32'd1);
    chk("mis_pc", pc, 32'd12);
    chk("mis_req", 32'(imem_req), 32'd0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("mis_req_hold", 32'(imem_req), 32'd0);
    chk("mis_pc_hold", pc, 32'd12);

    // Illegal instruction
    do_reset();
    chk("rst_clears_trap", 32'(trap), 32'd0);
    chk("rst_pc2", pc, 32'd0);
    to_exec(ILLEGAL, 1'b0);
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_req", 32'(imem_req), 32'd0);
    chk("ill_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk); imem_valid = 1'b1; #1;
    @(negedge clk); #1;
    chk("ill_req_hold", 32'(imem_req), 32'd0);
    chk("ill_trap_hold", 32'(trap), 32'd1);

    // Reset during EXEC of the second addi
    do_reset();
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    chk("pre_rst_pc", pc, 32'd4);
    to_exec(ADDI_X1, 1'b0);
    rst = 1'b1; #1;
    chk("rst_exec_regwrite", 32'(RegWrite), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_exec_pc", pc, 32'd0);
    chk("rst_exec_req", 32'(imem_req), 32'd1);

    // Three addi plus a taken bne, then an illegal instruction
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    to_exec(ADDI_X1, 1'b0);
    @(negedge clk); #1;
    chk("cnt_pc12", pc, 32'd12);
    to_exec(BNE_M8, 1'b0);
    @(negedge clk); #1;
    chk("cnt_pc4", pc, 32'd4);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    chk("retired_4", retired, 32'd4);
`endif
    to_exec(ILLEGAL, 1'b0);
    @(negedge clk); #1;
    chk("cnt_trap", 32'(trap), 32'd1);
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    chk("retired_hold", retired, 32'd4);
`endif

    // PC wrap from RESET_PC=0xFFFFFFFC
    @(negedge clk); run = 1'b0; w_rst = 1'b0; w_run = 1'b1; #1;
    chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    chk("wrap_req", 32'(w_req), 32'd1);
    @(negedge clk); w_valid = 1'b1; w_instr = ADDI_X1; #1;
    @(negedge clk); w_valid = 1'b0; #1;
    @(negedge clk); #1;
    chk("wrap_regwrite", 32'(w_regwrite), 32'd1);
    @(negedge clk); #1;
    chk("wrap_pc", w_pc, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
